// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types, width helpers and default limits for the servo PWM controller
//
// Purpose : common definitions imported by key_debounce and servo_pwm_multi.
// Contents: cmd_t key command encoding, w_bits()/center_w() helpers,
//           W_BITS/CENTER derived from the default pulse-width limits.
package servo_pkg;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DOWN = 2'd2
    } cmd_t;

    // Number of bits needed to hold every value in 0..n (at least one bit).
    function automatic int w_bits(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Neutral pulse width between the two travel limits.
    function automatic int center_w(input int lo, input int hi);
        return (lo + hi) / 2;
    endfunction

    localparam int DEF_MIN_W = 500;
    localparam int DEF_MAX_W = 2500;
    localparam int W_BITS    = w_bits(DEF_MAX_W);
    localparam int CENTER    = center_w(DEF_MIN_W, DEF_MAX_W);

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key synchroniser, debounce counter and rising-edge pulse
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   key_i    raw asynchronous button, active-high
//   pulse_o  one-cycle pulse on each 0->1 change of the debounced level
module key_debounce
    import servo_pkg::*;
#(
    parameter int DEB = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic pulse_o
);

    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synchronised input disagrees with the
    // debounced level; any agreement restarts it, so a flip needs DEB
    // consecutive disagreeing cycles.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = level_q & ~prev_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM with key-stepped, frame-aligned widths
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   key[1:0]     raw buttons, key[0] = up, key[1] = down
//   ch_sel       channel addressed by key commands (codes >= NCH are ignored)
//   pwm[NCH-1:0] registered servo outputs
//   frame_start  one-cycle pulse aligned with the rising edges of pwm
//   sel_width    registered target width of the channel selected by ch_sel
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int TICK_DIV = 50,
    parameter int PERIOD   = 20000,
    parameter int MIN_W    = 500,
    parameter int MAX_W    = 2500,
    parameter int STEP     = 100,
    parameter int DEB      = 500000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 key,
    input  logic [w_bits(NCH)-1:0]     ch_sel,
    output logic [NCH-1:0]             pwm,
    output logic                       frame_start,
    output logic [w_bits(MAX_W)-1:0]   sel_width
);

    localparam int CH_BITS = w_bits(NCH);
    localparam int WB      = w_bits(MAX_W);
    localparam int PB      = w_bits(PERIOD - 1);
    localparam int TB      = w_bits(TICK_DIV - 1);

    localparam logic [WB-1:0] CTR_V  = WB'(center_w(MIN_W, MAX_W));
    localparam logic [WB-1:0] MIN_V  = WB'(MIN_W);
    localparam logic [WB-1:0] MAX_V  = WB'(MAX_W);
    localparam logic [WB:0]   MIN_X  = (WB + 1)'(MIN_W);
    localparam logic [WB:0]   MAX_X  = (WB + 1)'(MAX_W);
    localparam logic [WB:0]   STEP_X = (WB + 1)'(STEP);

    // ------------------------------------------------------------------
    // Key front end
    // ------------------------------------------------------------------
    logic up_pulse;
    logic dn_pulse;
    cmd_t cmd;

    key_debounce #(.DEB(DEB)) u_deb_up (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key[0]),
        .pulse_o (up_pulse)
    );

    key_debounce #(.DEB(DEB)) u_deb_dn (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key[1]),
        .pulse_o (dn_pulse)
    );

    // Simultaneous up and down cancel each other.
    always_comb begin
        cmd = CMD_NONE;
        if (up_pulse && !dn_pulse) begin
            cmd = CMD_UP;
        end else if (dn_pulse && !up_pulse) begin
            cmd = CMD_DOWN;
        end
    end

    // ------------------------------------------------------------------
    // Target widths
    // ------------------------------------------------------------------
    logic [WB-1:0] tgt_q [NCH];
    logic [WB-1:0] tgt_d [NCH];
    logic [WB-1:0] act_q [NCH];
    logic [WB-1:0] act_d [NCH];
    logic [WB-1:0] cur_w;
    logic [WB-1:0] nxt_w;
    logic          sel_hit;
    logic [WB:0]   sum_x;
    logic [WB:0]   diff_x;
    logic [WB-1:0] sel_width_q;
    logic [WB-1:0] sel_width_d;

    // The channel mux is a compare loop rather than an array index so that
    // out-of-range ch_sel codes simply match nothing.
    always_comb begin
        cur_w   = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == CH_BITS'(i)) begin
                cur_w   = tgt_q[i];
                sel_hit = 1'b1;
            end
        end
    end

    // One extra bit keeps the sum from overflowing and exposes the borrow
    // of the difference, so neither direction can wrap past a limit.
    always_comb begin
        sum_x  = {1'b0, cur_w} + STEP_X;
        diff_x = {1'b0, cur_w} - STEP_X;
        nxt_w  = cur_w;
        case (cmd)
            CMD_UP:   nxt_w = (sum_x > MAX_X) ? MAX_V : sum_x[WB-1:0];
            CMD_DOWN: nxt_w = (diff_x[WB] || (diff_x < MIN_X)) ? MIN_V : diff_x[WB-1:0];
            default:  nxt_w = cur_w;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tgt_d[i] = tgt_q[i];
            if (ch_sel == CH_BITS'(i)) begin
                tgt_d[i] = nxt_w;
            end
        end
    end

    // Out-of-range selections hold the last reported width.
    always_comb begin
        sel_width_d = sel_width_q;
        if (sel_hit) begin
            sel_width_d = cur_w;
        end
    end

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic [TB-1:0] pre_q;
    logic [TB-1:0] pre_d;
    logic [PB-1:0] pcnt_q;
    logic [PB-1:0] pcnt_d;
    logic          tick;
    logic          wrap;
    logic          wrap_q;

    assign tick = (pre_q == TB'(TICK_DIV - 1));
    assign wrap = tick && (pcnt_q == PB'(PERIOD - 1));

    always_comb begin
        pre_d  = tick ? '0 : pre_q + TB'(1);
        pcnt_d = pcnt_q;
        if (tick) begin
            pcnt_d = wrap ? '0 : pcnt_q + PB'(1);
        end
    end

    // Shadow load takes tgt_d, so a command landing on the wrap cycle is
    // already part of the new frame.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            act_d[i] = wrap ? tgt_d[i] : act_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [NCH-1:0] pwm_q;
    logic [NCH-1:0] pwm_d;
    logic           frame_start_q;

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = (32'(pcnt_q) < 32'(act_q[i]));
        end
    end

    // wrap_q marks the first pcnt==0 cycle; frame_start follows it by one
    // cycle to line up with the registered pwm rising edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                tgt_q[i] <= CTR_V;
                act_q[i] <= CTR_V;
            end
            pre_q         <= '0;
            pcnt_q        <= '0;
            wrap_q        <= 1'b0;
            frame_start_q <= 1'b0;
            pwm_q         <= '0;
            sel_width_q   <= CTR_V;
        end else begin
            tgt_q         <= tgt_d;
            act_q         <= act_d;
            pre_q         <= pre_d;
            pcnt_q        <= pcnt_d;
            wrap_q        <= wrap;
            frame_start_q <= wrap_q;
            pwm_q         <= pwm_d;
            sel_width_q   <= sel_width_d;
        end
    end

    assign pwm         = pwm_q;
    assign frame_start = frame_start_q;
    assign sel_width   = sel_width_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - scoreboard bench for servo_pwm_multi
module tb_servo_pwm_multi;

    localparam int NCH      = 2;
    localparam int TICK_DIV = 2;
    localparam int PERIOD   = 100;
    localparam int MIN_W    = 10;
    localparam int MAX_W    = 30;
    localparam int STEP     = 5;
    localparam int DEB      = 4;
    localparam int FRAME    = PERIOD * TICK_DIV;
    localparam int CENTER   = (MIN_W + MAX_W) / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key;
    logic [1:0] ch_sel;
    logic [1:0] pwm;
    logic       frame_start;
    logic [4:0] sel_width;

    servo_pwm_multi #(
        .NCH(NCH), .TICK_DIV(TICK_DIV), .PERIOD(PERIOD), .MIN_W(MIN_W),
        .MAX_W(MAX_W), .STEP(STEP), .DEB(DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .ch_sel      (ch_sel),
        .pwm         (pwm),
        .frame_start (frame_start),
        .sel_width   (sel_width)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w0;
        int w1;
        int sel;
        bit sel_ok;
    } exp_t;

    exp_t        sb_q[$];
    int          m_tgt [NCH];
    int          m_ch;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t make_entry();
        exp_t e;
        e.w0     = m_tgt[0];
        e.w1     = m_tgt[1];
        e.sel_ok = (m_ch < NCH);
        e.sel    = (m_ch < NCH) ? m_tgt[m_ch] : 0;
        return e;
    endfunction

    // Reference model: frames are FRAME cycles long starting at reset
    // release; each new frame takes the model targets current at its start.
    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
        end else begin
            cyc = cyc + 1;
            if ((cyc % FRAME) == 0) sb_q.push_back(make_entry());
        end
    end

    // Monitor: measure each frame between frame_start pulses.
    exp_t cur;
    exp_t nxt;
    bit   armed = 0;
    int   hi0, hi1, flen;

    always @(negedge clk) begin
        if (rst) begin
            armed = 0;
        end else if (cyc >= 1) begin
            if (!armed) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty_start", 0, 1);
                end else begin
                    cur = sb_q.pop_front();
                end
                armed = 1;
                hi0 = 0; hi1 = 0; flen = 0;
            end
            if (frame_start) begin
                check("frame_len", flen, FRAME);
                check("pwm0_high", hi0, cur.w0 * TICK_DIV);
                check("pwm1_high", hi1, cur.w1 * TICK_DIV);
                if (sb_q.size() == 0) begin
                    check("sb_empty_frame", 0, 1);
                end else begin
                    nxt = sb_q.pop_front();
                    if (nxt.sel_ok) check("sel_width_frame", int'(sel_width), nxt.sel);
                    cur = nxt;
                end
                hi0 = 0; hi1 = 0; flen = 0;
            end
            flen = flen + 1;
            hi0  = hi0 + int'(pwm[0]);
            hi1  = hi1 + int'(pwm[1]);
            if (flen == FRAME + 8) begin
                check("frame_timeout", flen, FRAME);
                flen = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_phase(input int lo, input int hi);
        int guard = 0;
        do begin
            step(1);
            guard++;
        end while (!(((cyc % FRAME) >= lo) && ((cyc % FRAME) <= hi)) && guard < 4 * FRAME);
        if (guard >= 4 * FRAME) check("phase_timeout", guard, 0);
    endtask

    task automatic apply_model(input logic [1:0] kmask, input int ch, input int len);
        if (len >= DEB && kmask != 2'b11 && ch < NCH) begin
            if (kmask == 2'b01) m_tgt[ch] = (m_tgt[ch] + STEP > MAX_W) ? MAX_W : m_tgt[ch] + STEP;
            else                m_tgt[ch] = (m_tgt[ch] - STEP < MIN_W) ? MIN_W : m_tgt[ch] - STEP;
        end
    endtask

    // Presses start early enough in a frame that the command lands before
    // the next wrap, so the model can apply it at frame granularity.
    task automatic press(input logic [1:0] kmask, input int ch, input int len);
        wait_phase(10, 120);
        ch_sel = 2'(ch);
        m_ch   = ch;
        apply_model(kmask, ch, len);
        key = kmask;
        step(len);
        key = 2'b00;
        step(12);
    endtask

    task automatic bounce_press(input logic [1:0] kmask, input int ch);
        wait_phase(10, 100);
        ch_sel = 2'(ch);
        m_ch   = ch;
        apply_model(kmask, ch, 10);
        repeat (3) begin
            key = kmask;
            step(3);
            key = 2'b00;
            step(3);
        end
        key = kmask;
        step(10);
        key = 2'b00;
        step(12);
    endtask

    task automatic release_reset();
        ch_sel = 2'd0;
        m_ch   = 0;
        for (int i = 0; i < NCH; i++) m_tgt[i] = CENTER;
        sb_q.delete();
        sb_q.push_back(make_entry());
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        key    = 2'b00;
        ch_sel = 2'd0;
        step(3);
        check("rst_pwm", int'(pwm), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_sel_width", int'(sel_width), CENTER);
        release_reset();
        step(3);
        check("idle_sel_width", int'(sel_width), CENTER);
        step(2 * FRAME + 20);

        press(2'b01, 1, 6);
        check("up_ch1_sel", int'(sel_width), 25);

        bounce_press(2'b10, 0);
        check("bounce_down_ch0_sel", int'(sel_width), 15);

        press(2'b01, 0, DEB - 1);
        check("short_press_sel", int'(sel_width), 15);

        for (int i = 0; i < 6; i++) press(2'b01, 0, 6);
        check("sat_max_sel", int'(sel_width), MAX_W);
        for (int i = 0; i < 10; i++) press(2'b10, 0, 6);
        check("sat_min_sel", int'(sel_width), MIN_W);

        press(2'b11, 0, 8);
        check("both_keys_sel", int'(sel_width), MIN_W);
        press(2'b01, 2, 8);
        ch_sel = 2'd0;
        m_ch   = 0;
        step(3);
        check("out_of_range_sel", int'(sel_width), MIN_W);
        ch_sel = 2'd1;
        m_ch   = 1;
        step(3);
        check("out_of_range_ch1", int'(sel_width), 25);

        for (int n = 0; n < 20; n++) begin
            press(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                  int'($urandom_range(1, 9)));
        end
        step(FRAME + 10);

        // Reset while every pwm is still inside its high phase.
        wait_phase(3, 15);
        check("pre_rst_pwm", int'(pwm), 3);
        rst = 1'b1;
        #1;
        check("mid_rst_pwm", int'(pwm), 0);
        check("mid_rst_frame_start", int'(frame_start), 0);
        check("mid_rst_sel_width", int'(sel_width), CENTER);
        step(4);
        release_reset();
        step(3);
        check("post_rst_sel_width", int'(sel_width), CENTER);
        step(3 * FRAME);
        wait_phase(50, 60);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
